// File: rtl/nco_tremolo_pkg.sv
// Shared widths, constants and LFO-to-gain arithmetic for the tremolo stage.
package nco_tremolo_pkg;

  localparam int unsigned MPR    = 16;
  localparam int unsigned DW     = 16;
  localparam int unsigned DPW    = 8;
  localparam int unsigned GAIN_W = 17;
  localparam int unsigned SHIFT  = 16;
  localparam int unsigned PROD_W = DW + GAIN_W + 1;
  localparam int unsigned ATT_W  = MPR + DPW;

  typedef logic [GAIN_W-1:0] gain_t;

  localparam gain_t          GAIN_UNITY = GAIN_W'(65536);
  localparam logic [MPR-1:0] LFO_OFFSET = {1'b1, {(MPR-1){1'b0}}};

  // gain = 65536 - ((depth * (65535 - u)) >> 8), where u is the LFO moved to unsigned
  function automatic gain_t lfo_to_gain(input logic [MPR-1:0] lfo,
                                        input logic [DPW-1:0] depth);
    logic [MPR-1:0]   u;
    logic [MPR-1:0]   inv;
    logic [ATT_W-1:0] prod;
    logic [MPR-1:0]   att;
    u    = lfo + LFO_OFFSET;
    inv  = ~u;
    prod = ATT_W'(depth) * ATT_W'(inv);
    att  = MPR'(prod >> DPW);
    return GAIN_UNITY - GAIN_W'(att);
  endfunction

endpackage

// File: rtl/nco_tremolo_gain.sv
// Registered conversion of the NCO sine sample into an unsigned audio gain.
module nco_tremolo_gain
  import nco_tremolo_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic [MPR-1:0] lfo_i,
  input  logic           lfo_valid,
  input  logic [DPW-1:0] depth_i,
  output gain_t          gain_o,
  output logic           lfo_seen_o
);

  gain_t gain_q, gain_d;
  logic  lfo_seen_q, lfo_seen_d;

  // Recompute the gain only when an LFO sample is accepted; depth is sampled with it
  always_comb begin
    gain_d     = gain_q;
    lfo_seen_d = lfo_seen_q;
    if (clken && lfo_valid) begin
      gain_d     = lfo_to_gain(lfo_i, depth_i);
      lfo_seen_d = 1'b1;
    end
  end

  // Gain state register, unity until the first LFO sample arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gain_q     <= GAIN_UNITY;
      lfo_seen_q <= 1'b0;
    end else begin
      gain_q     <= gain_d;
      lfo_seen_q <= lfo_seen_d;
    end
  end

  assign gain_o     = gain_q;
  assign lfo_seen_o = lfo_seen_q;

endmodule

// File: rtl/nco_tremolo_mod.sv
// Tremolo stage: two-cycle audio capture/multiply pipeline driven by the NCO-derived gain.
module nco_tremolo_mod
  import nco_tremolo_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clken,
  input  logic [MPR-1:0] lfo_i,
  input  logic          lfo_valid,
  input  logic [DPW-1:0] depth_i,
  input  logic          bypass_i,
  input  logic [DW-1:0] audio_i,
  input  logic          audio_valid,
  output logic [DW-1:0] audio_o,
  output logic          audio_o_valid
);

  gain_t gain;
  logic  lfo_seen;

  nco_tremolo_gain u_gain (
    .clk        (clk),
    .reset      (reset),
    .clken      (clken),
    .lfo_i      (lfo_i),
    .lfo_valid  (lfo_valid),
    .depth_i    (depth_i),
    .gain_o     (gain),
    .lfo_seen_o (lfo_seen)
  );

  logic [DW-1:0]  s1_audio_q, s1_audio_d;
  gain_t          s1_gain_q, s1_gain_d;
  logic           s1_valid_q, s1_valid_d;
  logic [DW-1:0]  audio_o_q, audio_o_d;
  logic           audio_o_valid_q, audio_o_valid_d;
  logic signed [PROD_W-1:0] prod;

  // S1 captures the sample with the gain in force before any same-cycle LFO update
  always_comb begin
    s1_audio_d = s1_audio_q;
    s1_gain_d  = s1_gain_q;
    s1_valid_d = s1_valid_q;
    if (clken) begin
      s1_valid_d = audio_valid;
      if (audio_valid) begin
        s1_audio_d = audio_i;
        s1_gain_d  = (bypass_i || !lfo_seen) ? GAIN_UNITY : gain;
      end
    end
  end

  // S2 multiplies signed audio by unsigned gain and floors back to audio width
  always_comb begin
    prod = $signed({{(PROD_W-DW){s1_audio_q[DW-1]}}, s1_audio_q})
         * $signed({{(PROD_W-GAIN_W){1'b0}}, s1_gain_q});
    audio_o_d       = audio_o_q;
    audio_o_valid_d = audio_o_valid_q;
    if (clken) begin
      audio_o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        audio_o_d = DW'(prod >>> SHIFT);
      end
    end
  end

  // Pipeline registers; reset drops any in-flight sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_audio_q      <= '0;
      s1_gain_q       <= GAIN_UNITY;
      s1_valid_q      <= 1'b0;
      audio_o_q       <= '0;
      audio_o_valid_q <= 1'b0;
    end else begin
      s1_audio_q      <= s1_audio_d;
      s1_gain_q       <= s1_gain_d;
      s1_valid_q      <= s1_valid_d;
      audio_o_q       <= audio_o_d;
      audio_o_valid_q <= audio_o_valid_d;
    end
  end

  assign audio_o       = audio_o_q;
  assign audio_o_valid = audio_o_valid_q;

endmodule

// File: tb/tb_nco_tremolo_mod.sv
// Directed bench for nco_tremolo_mod: vector table plus multi-cycle corner sequences.
module tb_nco_tremolo_mod;

  logic        clk = 1'b0;
  logic        reset;
  logic        clken;
  logic [15:0] lfo_i;
  logic        lfo_valid;
  logic [7:0]  depth_i;
  logic        bypass_i;
  logic [15:0] audio_i;
  logic        audio_valid;
  logic [15:0] audio_o;
  logic        audio_o_valid;

  int n_checks = 0;
  int n_pass   = 0;

  nco_tremolo_mod dut (
    .clk           (clk),
    .reset         (reset),
    .clken         (clken),
    .lfo_i         (lfo_i),
    .lfo_valid     (lfo_valid),
    .depth_i       (depth_i),
    .bypass_i      (bypass_i),
    .audio_i       (audio_i),
    .audio_valid   (audio_valid),
    .audio_o       (audio_o),
    .audio_o_valid (audio_o_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [15:0] lfo;
    logic [7:0]  depth;
    logic        byp;
    logic [15:0] audio;
    logic [15:0] exp_o;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp_v);
    n_checks++;
    if (got == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
  endtask

  task automatic load_lfo(input logic [15:0] l, input logic [7:0] d);
    lfo_i     = l;
    depth_i   = d;
    lfo_valid = 1'b1;
    step();
    lfo_valid = 1'b0;
    depth_i   = 8'h5A;
    step();
  endtask

  task automatic send_audio(input string nm, input logic [15:0] a, input logic byp,
                            input logic [15:0] e);
    audio_i     = a;
    bypass_i    = byp;
    audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    bypass_i    = 1'b0;
    check({nm, "_lat1_valid"}, int'(audio_o_valid), 0);
    step();
    check({nm, "_valid"}, int'(audio_o_valid), 1);
    check({nm, "_data"}, int'($signed(audio_o)), int'($signed(e)));
    step();
    check({nm, "_strobe_end"}, int'(audio_o_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 16'sd0,     8'd0,   1'b0, 16'sd1000,   16'sd1000};
    vecs[1] = '{1'b1, -16'sd32768, 8'd255, 1'b0, 16'sd32767,  16'sd128};
    vecs[2] = '{1'b0, 16'sd0,     8'd0,   1'b0, -16'sd32768, -16'sd129};
    vecs[3] = '{1'b1, 16'sd0,     8'd128, 1'b0, 16'sd16384,  16'sd12288};
    vecs[4] = '{1'b1, 16'sd12345, 8'd0,   1'b0, -16'sd5000,  -16'sd5000};
    vecs[5] = '{1'b1, -16'sd32768, 8'd255, 1'b1, -16'sd5000,  -16'sd5000};
    vecs[6] = '{1'b1, 16'sd32767, 8'd255, 1'b0, -16'sd1,     -16'sd1};
    vecs[7] = '{1'b1, -16'sd1,    8'd255, 1'b0, 16'sd20000,  16'sd10039};
    vecs[8] = '{1'b0, 16'sd0,     8'd0,   1'b0, -16'sd20000, -16'sd10040};
    vecs[9] = '{1'b0, 16'sd0,     8'd0,   1'b0, 16'sd0,      16'sd0};

    reset = 1'b1; clken = 1'b1; lfo_i = '0; lfo_valid = 1'b0; depth_i = '0;
    bypass_i = 1'b0; audio_i = '0; audio_valid = 1'b0;
    step(); step();
    check("reset_audio_o", int'(audio_o), 0);
    check("reset_valid", int'(audio_o_valid), 0);
    reset = 1'b0;
    step();
    check("post_reset_valid", int'(audio_o_valid), 0);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].lv) load_lfo(vecs[i].lfo, vecs[i].depth);
      send_audio($sformatf("vec%0d", i), vecs[i].audio, vecs[i].byp, vecs[i].exp_o);
    end

    // same-cycle LFO and audio: old unity gain applies, new gain on next sample
    load_lfo(16'sd32767, 8'd255);
    lfo_i = -16'sd32768; depth_i = 8'd255; lfo_valid = 1'b1;
    audio_i = 16'sd32767; audio_valid = 1'b1;
    step();
    lfo_valid = 1'b0;
    check("same_lat1_valid", int'(audio_o_valid), 0);
    step();
    audio_valid = 1'b0;
    check("same_old_valid", int'(audio_o_valid), 1);
    check("same_old_data", int'($signed(audio_o)), 32767);
    step();
    check("same_new_valid", int'(audio_o_valid), 1);
    check("same_new_data", int'($signed(audio_o)), 128);
    step();
    check("same_end_valid", int'(audio_o_valid), 0);

    // clken low mid-pipeline stalls the sample; audio offered while stalled is dropped
    audio_i = 16'sd1000; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    clken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      audio_i = 16'sd7777; audio_valid = (k == 1);
      step();
      check($sformatf("stall%0d_valid", k), int'(audio_o_valid), 0);
    end
    audio_valid = 1'b0;
    clken = 1'b1;
    step();
    check("stall_out_valid", int'(audio_o_valid), 1);
    check("stall_out_data", int'($signed(audio_o)), 3);
    step();
    check("stall_no_extra", int'(audio_o_valid), 0);
    check("hold_data", int'($signed(audio_o)), 3);

    // reset between S1 and S2 discards the in-flight sample and restores unity gain
    audio_i = 16'sd500; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", int'(audio_o_valid), 0);
    check("rst_mid_audio", int'(audio_o), 0);
    step();
    reset = 1'b0;
    step();
    check("rst_after_valid", int'(audio_o_valid), 0);
    step();
    check("rst_after_valid2", int'(audio_o_valid), 0);
    send_audio("rst_unity", 16'sd1000, 1'b0, 16'sd1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nco_tremolo_mod.md
Name: nco_tremolo_mod

Overview:
Amplitude-modulation (tremolo) stage directly downstream of the NCO oscillator in the effects pedal.
- Consumes the NCO sine sample (fsin_o / out_valid) as an LFO.
- Converts it to a depth-scaled unsigned gain and multiplies each incoming audio sample by that gain.
- Emits the modulated audio sample with a valid strobe to the next effect stage or codec interface.

Parameters:
mpr, 16, LFO sample width (matches NCO magnitude precision; signed two's complement)
dw, 16, audio sample width (signed two's complement)
dpw, 8, depth control width (unsigned; 0 = no modulation)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-high reset
clken  in  1  global clock enable; low = every register holds
lfo_i  in  mpr  signed LFO sample from NCO fsin_o
lfo_valid  in  1  LFO sample strobe from NCO out_valid
depth_i  in  dpw  modulation depth, sampled only on LFO acceptance
bypass_i  in  1  1 = pass audio unmodified (gain forced to unity), sampled on audio acceptance
audio_i  in  dw  signed audio input sample
audio_valid  in  1  audio input strobe, single-cycle pulse per sample
audio_o  out  dw  modulated signed audio sample
audio_o_valid  out  1  single-cycle output strobe

Behaviour:
- Reset (async, immediate) values:
  - audio_o = 0, audio_o_valid = 0.
  - Gain register = 65536 (unity); lfo_seen = 0.
  - All pipeline valid bits = 0.
- clken = 0: no register updates and no strobes accepted; inputs presented during that cycle are dropped.
- LFO acceptance (lfo_valid & clken):
  - u = lfo_i + 2^(mpr-1), unsigned 0..65535.
  - att = (depth_i * (65535 - u)) >> 8; floor, max 65279.
  - gain = 65536 - att; 17-bit unsigned, range 257..65536. Registered one cycle after acceptance.
  - Sets lfo_seen = 1.
- Until the first LFO acceptance after reset, gain stays at 65536, so audio passes unchanged.
- Audio pipeline, fixed latency 2 enabled cycles, no backpressure:
  - S1 (audio_valid & clken): capture audio_i, the current gain register (or 65536 if bypass_i = 1), and valid.
  - S2: p = signed(audio) * unsigned(gain), 34-bit signed; audio_o = p >>> 16 (arithmetic shift, floor); audio_o_valid = 1 for one enabled cycle.
- Result always fits dw bits because gain ≤ 65536; no saturation logic required.
- Simultaneous lfo_valid and audio_valid in the same cycle: the audio sample uses the OLD gain; the new gain applies from the next audio sample.
- Back-to-back audio_valid on consecutive cycles is fully supported (pipeline throughput 1/cycle).
- audio_o holds its last value while audio_o_valid = 0.
- Reset mid-operation: in-flight samples are discarded and no output strobe is produced for them.
- The depth_i value applies only to the gain computed at the next LFO acceptance. Depth changes between LFO samples have no effect.

Decomposition:
- Package nco_tremolo_pkg:
  - width constants: MPR, DW, DPW, GAIN_W = 17
  - GAIN_UNITY = 65536
  - LFO_OFFSET = 2^(MPR-1)
  - gain_t typedef
- Sub-module nco_tremolo_gain: registered LFO-to-gain conversion with lfo_seen tracking.
- Top level contains the audio capture/multiply pipeline.

Test Plan:
1. No LFO after reset; audio_i = 1000 with valid -> audio_o = 1000, audio_o_valid exactly 2 cycles later.
2. lfo_i = -32768, depth_i = 255; then audio 32767 -> gain = 257, audio_o = 128. Then audio -32768 -> audio_o = -129.
3. lfo_i = 0, depth_i = 128; audio 16384 -> gain = 49153, audio_o = 12288.
4. depth_i = 0 with any lfo_i (e.g. 12345); audio -5000 -> audio_o = -5000. Same -5000 with bypass_i = 1, depth = 255, lfo = -32768 -> -5000.
5. lfo_valid and audio_valid in the same cycle (old gain 65536, new lfo = -32768, depth = 255):
   - audio 32767 -> 32767.
   - Next audio 32767 -> 128.
6. clken low for 3 cycles mid-pipeline -> output delayed by 3 cycles, value unchanged. Then assert reset between S1 and S2 -> no audio_o_valid; audio_o = 0 and gain = 65536 after release.
